// File: rtl/cl_vled_pattern_gen.sv
// Virtual LED pattern generator: DIP-selected pass-through, blink, chase or binary count at a DIP-selected speed.
// Optional macro CL_VLED_PWM_EN adds registered brightness gating from vdip[9:6].
module cl_vled_pattern_gen #(
  parameter int TICK_SHIFT = 20,
  parameter int LED_W      = 16
) (
  input  logic             clk_main_a0,
  input  logic             rst_main,
  input  logic [LED_W-1:0] vdip,
  output logic [LED_W-1:0] vled,
  output logic             led_tick,
  output logic [1:0]       cur_mode
);

  localparam int PW = TICK_SHIFT + 16;
  localparam logic [PW-1:0] PRESC_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  mode_t            mode_q;
  mode_t            mode_in;
  logic [3:0]       speed_q;
  logic [3:0]       speed_in;
  logic             hold;
  logic             chg;
  logic             tick;
  logic [PW-1:0]    prescaler;
  logic [PW-1:0]    presc_next;
  logic [PW-1:0]    terminal;
  logic [LED_W-1:0] vled_q;
  logic [LED_W-1:0] vled_next;
  logic             tick_q;

  assign mode_in  = mode_t'(vdip[1:0]);
  assign speed_in = vdip[5:2];
  assign hold     = vdip[15];
  assign terminal = (PRESC_ONE << (TICK_SHIFT + int'(speed_q))) - PRESC_ONE;

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      mode_q    <= MODE_PASS;
      speed_q   <= '0;
      prescaler <= '0;
      vled_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode_in;
      speed_q   <= speed_in;
      prescaler <= presc_next;
      vled_q    <= vled_next;
      tick_q    <= tick;
    end
  end

  // A mode/speed change restarts the pattern and swallows any tick due that cycle; hold freezes everything else.
  always_comb begin
    presc_next = prescaler;
    vled_next  = vled_q;
    chg        = (mode_in != mode_q) || (speed_in != speed_q);
    tick       = (prescaler == terminal) && !hold && !chg;
    if (chg) begin
      presc_next = '0;
      case (mode_in)
        MODE_PASS:  vled_next = vdip;
        MODE_BLINK: vled_next = '1;
        MODE_CHASE: vled_next = {{(LED_W-1){1'b0}}, 1'b1};
        MODE_COUNT: vled_next = '0;
      endcase
    end else if (!hold) begin
      presc_next = tick ? '0 : prescaler + PRESC_ONE;
      case (mode_q)
        MODE_PASS:  vled_next = vdip;
        MODE_BLINK: if (tick) vled_next = ~vled_q;
        MODE_CHASE: if (tick) vled_next = {vled_q[LED_W-2:0], vled_q[LED_W-1]};
        MODE_COUNT: if (tick) vled_next = vled_q + {{(LED_W-1){1'b0}}, 1'b1};
      endcase
    end
  end

  assign cur_mode = mode_q;

`ifdef CL_VLED_PWM_EN
  logic [3:0] pwm_cnt;

  // Gating is registered, so led_tick gets one matching stage of delay.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      pwm_cnt  <= '0;
      vled     <= '0;
      led_tick <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 4'd1;
      vled     <= vled_q & {LED_W{pwm_cnt <= vdip[9:6]}};
      led_tick <= tick_q;
    end
  end
`else
  assign vled     = vled_q;
  assign led_tick = tick_q;
`endif

endmodule

// File: tb/tb_cl_vled_pattern_gen.sv
// Bench for cl_vled_pattern_gen (default build): directed pattern scenarios plus random DIP traffic,
// each cycle compared against a tick-count model of the display.
module tb_cl_vled_pattern_gen;

  localparam int TS = 0;

  logic        clk;
  logic        rst;
  logic [15:0] vdip;
  logic [15:0] vled;
  logic        led_tick;
  logic [1:0]  cur_mode;

  int vectors;
  int miscompares;

  logic [1:0]  m_mode;
  logic [3:0]  m_speed;
  longint      m_phase;
  int          n_ticks;
  logic [15:0] m_vled;
  logic        m_tick;

  cl_vled_pattern_gen #(
    .TICK_SHIFT(TS),
    .LED_W(16)
  ) dut (
    .clk_main_a0(clk),
    .rst_main(rst),
    .vdip(vdip),
    .vled(vled),
    .led_tick(led_tick),
    .cur_mode(cur_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display after n ticks since the pattern (re)started, derived directly from the mode's definition.
  function automatic logic [15:0] pattern_at(input logic [1:0] mode, input int n, input logic [15:0] v);
    logic [15:0] r;
    case (mode)
      2'b00:   r = v;
      2'b01:   r = (n % 2 == 1) ? 16'h0000 : 16'hFFFF;
      2'b10:   r = 16'h0001 << (n % 16);
      default: r = 16'(n);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mode  = 2'b00;
    m_speed = 4'd0;
    m_phase = 0;
    n_ticks = 0;
    m_vled  = 16'h0000;
    m_tick  = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] v);
    longint period;
    if (v[1:0] != m_mode || v[5:2] != m_speed) begin
      m_mode  = v[1:0];
      m_speed = v[5:2];
      m_phase = 0;
      n_ticks = 0;
      m_tick  = 1'b0;
      m_vled  = pattern_at(m_mode, 0, v);
    end else if (v[15]) begin
      m_tick = 1'b0;
    end else begin
      period  = longint'(1) << (TS + int'(m_speed));
      m_phase = m_phase + 1;
      m_tick  = (m_phase % period) == 0;
      if (m_tick) n_ticks = n_ticks + 1;
      m_vled  = pattern_at(m_mode, n_ticks, v);
    end
  endtask

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check_value({tag, ".vled"}, vled, m_vled);
    check_value({tag, ".led_tick"}, {15'd0, led_tick}, {15'd0, m_tick});
    check_value({tag, ".cur_mode"}, {14'd0, cur_mode}, {14'd0, m_mode});
  endtask

  task automatic applyStimulus(input logic [15:0] v, input string tag);
    vdip = v;
    @(posedge clk);
    model_step(v);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [15:0] rv;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    vdip        = 16'h0000;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;
    repeat (3) applyStimulus(16'h0000, "pass_zero");

    $display("[TB] pass-through and hold");
    applyStimulus(16'hA5A0, "pass_load");
    check_value("pass_load_const", vled, 16'hA5A0);
    applyStimulus(16'hA4A0, "pass_hold_a");
    applyStimulus(16'hA5A0, "pass_hold_b");
    applyStimulus(16'hA4A0, "pass_hold_c");
    check_value("pass_hold_const", vled, 16'hA5A0);
    applyStimulus(16'h25A0, "pass_release");
    check_value("pass_release_const", vled, 16'h25A0);

    $display("[TB] chase rotation, period 4");
    applyStimulus(16'h000A, "chase_start");
    check_value("chase_start_const", vled, 16'h0001);
    repeat (3) applyStimulus(16'h000A, "chase_wait");
    check_value("chase_no_tick", {15'd0, led_tick}, 16'd0);
    applyStimulus(16'h000A, "chase_tick1");
    check_value("chase_tick1_flag", {15'd0, led_tick}, 16'd1);
    check_value("chase_tick1_vled", vled, 16'h0002);
    repeat (56) applyStimulus(16'h000A, "chase_run");
    check_value("chase_msb", vled, 16'h8000);
    repeat (4) applyStimulus(16'h000A, "chase_wrap");
    check_value("chase_wrap_const", vled, 16'h0001);

    $display("[TB] count at period 8");
    repeat (30) applyStimulus(16'h000F, "count_slow");

    $display("[TB] mode change on a due tick");
    applyStimulus(16'h0005, "blink_start");
    check_value("blink_start_const", vled, 16'hFFFF);
    applyStimulus(16'h0005, "blink_wait");
    applyStimulus(16'h0006, "coincide");
    check_value("coincide_tick", {15'd0, led_tick}, 16'd0);
    check_value("coincide_vled", vled, 16'h0001);
    applyStimulus(16'h0006, "coincide_after1");
    check_value("coincide_after1_tick", {15'd0, led_tick}, 16'd0);
    applyStimulus(16'h0006, "coincide_after2");
    check_value("coincide_after2_vled", vled, 16'h0002);

    $display("[TB] reset during count");
    applyStimulus(16'h0003, "count_start");
    repeat (35) applyStimulus(16'h0003, "count_run");
    check_value("count_23", vled, 16'h0023);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("async_reset");
    vdip = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) applyStimulus(16'h0000, "post_reset");
    applyStimulus(16'h0040, "post_reset_track");
    check_value("post_reset_track_const", vled, 16'h0040);

    $display("[TB] count wrap, period 1");
    applyStimulus(16'h0003, "wrap_start");
    repeat (65535) applyStimulus(16'h0003, "wrap_run");
    check_value("wrap_ffff", vled, 16'hFFFF);
    applyStimulus(16'h0003, "wrap_zero");
    check_value("wrap_zero_const", vled, 16'h0000);

    $display("[TB] random traffic");
    rv = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 6) begin
        rv[1:0] = 2'($urandom_range(0, 3));
        rv[5:2] = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 99) < 8) rv[15] = ~rv[15];
      rv[14:6] = 9'($urandom);
      applyStimulus(rv, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
